// File: rtl/pc_update_sequencer_pkg.sv
// Shared constants and state type for the PC update sequencer.
// PC-source selects, pc_op encodings, exception cause codes and FSM states.
package pc_update_sequencer_pkg;

    localparam logic [2:0] SRC_LSDATA = 3'd0;
    localparam logic [2:0] SRC_ALU    = 3'd1;
    localparam logic [2:0] SRC_ALUOUT = 3'd2;
    localparam logic [2:0] SRC_JUMP   = 3'd3;
    localparam logic [2:0] SRC_EPC    = 3'd4;

    localparam logic [2:0] OP_SEQ    = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_JR     = 3'd3;
    localparam logic [2:0] OP_RTE    = 3'd4;

    localparam logic [1:0] CAUSE_OPCODE = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_DIV0   = 2'd2;
    localparam logic [1:0] CAUSE_ALIGN  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DEC,
        ST_RESOLVE,
        ST_EXC_EPC,
        ST_EXC_MEM,
        ST_EXC_LOAD
    } state_e;

endpackage

// File: rtl/pc_update_sequencer_vec_wait_counter.sv
// Down-counter timing the exception vector read; loaded with MEM_WAIT-1
// so that expiry is seen after exactly MEM_WAIT cycles of counting.
module vec_wait_counter #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [3:0] LOAD_VAL = 4'(MEM_WAIT - 1);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (en_i && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign expired_o = (cnt_q == 4'd0);

endmodule

// File: rtl/pc_update_sequencer.sv
// Sequences every PC/EPC write, including exception entry via a vector fetch.
// Optional macro PC_ALIGN_CHECK_EN traps misaligned JUMP/JR/taken-BRANCH targets.
module pc_update_sequencer
    import pc_update_sequencer_pkg::*;
#(
    parameter int          MEM_WAIT = 2,
    parameter logic [31:0] VEC_BASE = 32'd253
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        instr_valid,
    input  logic [2:0]  pc_op,
    input  logic        branch_taken,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [1:0]  target_lo,
    output logic [2:0]  pc_source,
    output logic        pc_write,
    output logic        epc_write,
    output logic        mem_read,
    output logic [31:0] vec_addr,
    output logic [1:0]  exc_cause,
    output logic        busy,
    output logic        done
);

    state_e      state_q, state_d;
    logic [2:0]  pc_source_q, pc_source_d;
    logic        pc_write_q, pc_write_d, epc_write_q, epc_write_d;
    logic        mem_read_q, mem_read_d, busy_q, busy_d, done_q, done_d;
    logic [31:0] vec_addr_q, vec_addr_d;
    logic [1:0]  cause_q, cause_d;
    logic        misalign_q, misalign_d;
    logic        cnt_load, cnt_en, cnt_expired;
    logic        illegal_op, exc_now, res_write, align_bad;
    logic [2:0]  res_src;
    logic [1:0]  exc_sel;

    vec_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk       (clk),
        .reset     (reset),
        .load_i    (cnt_load),
        .en_i      (cnt_en),
        .expired_o (cnt_expired)
    );

    // Decode of the instruction presented with instr_valid.
    always_comb begin
        illegal_op = (pc_op > OP_RTE);
        exc_now    = exc_opcode | illegal_op | exc_overflow | exc_div0;
        exc_sel    = (exc_opcode | illegal_op) ? CAUSE_OPCODE :
                     exc_overflow ? CAUSE_OVF : CAUSE_DIV0;
        res_write  = 1'b0;
        res_src    = pc_source_q;
        case (pc_op)
            OP_BRANCH: begin res_write = branch_taken; res_src = SRC_ALUOUT; end
            OP_JUMP:   begin res_write = 1'b1;         res_src = SRC_JUMP;   end
            OP_JR:     begin res_write = 1'b1;         res_src = SRC_ALU;    end
            OP_RTE:    begin res_write = 1'b1;         res_src = SRC_EPC;    end
            default:   ;
        endcase
`ifdef PC_ALIGN_CHECK_EN
        align_bad = res_write && (pc_op != OP_RTE) && (target_lo != 2'd0);
`else
        align_bad = 1'b0;
`endif
    end

`ifndef PC_ALIGN_CHECK_EN
    logic unused_target_lo;
    assign unused_target_lo = ^target_lo;
`endif

    // Outputs are computed for the state being entered and then registered,
    // so each strobe lines up with the state that owns it.
    always_comb begin
        state_d     = state_q;
        pc_source_d = pc_source_q;
        pc_write_d  = 1'b0;
        epc_write_d = 1'b0;
        mem_read_d  = 1'b0;
        vec_addr_d  = 32'd0;
        done_d      = 1'b0;
        cause_d     = cause_q;
        misalign_d  = misalign_q;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fetch_req && !done_q) begin
                    state_d     = ST_FETCH;
                    pc_write_d  = 1'b1;
                    pc_source_d = SRC_ALU;
                end
            end
            ST_FETCH: state_d = ST_WAIT_DEC;
            ST_WAIT_DEC: begin
                if (instr_valid) begin
                    if (exc_now) begin
                        state_d     = ST_EXC_EPC;
                        epc_write_d = 1'b1;
                        cause_d     = exc_sel;
                    end else begin
                        state_d    = ST_RESOLVE;
                        misalign_d = align_bad;
                        done_d     = !align_bad;
                        if (res_write && !align_bad) begin
                            pc_write_d  = 1'b1;
                            pc_source_d = res_src;
                        end
                    end
                end
            end
            ST_RESOLVE: begin
                if (misalign_q) begin
                    state_d     = ST_EXC_EPC;
                    epc_write_d = 1'b1;
                    cause_d     = CAUSE_ALIGN;
                    misalign_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXC_EPC: begin
                state_d    = ST_EXC_MEM;
                cnt_load   = 1'b1;
                mem_read_d = 1'b1;
                vec_addr_d = VEC_BASE + {30'd0, cause_q};
            end
            ST_EXC_MEM: begin
                if (cnt_expired) begin
                    state_d     = ST_EXC_LOAD;
                    pc_write_d  = 1'b1;
                    pc_source_d = SRC_LSDATA;
                end else begin
                    cnt_en     = 1'b1;
                    mem_read_d = 1'b1;
                    vec_addr_d = VEC_BASE + {30'd0, cause_q};
                end
            end
            ST_EXC_LOAD: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_source_q <= SRC_LSDATA;
            pc_write_q  <= 1'b0;
            epc_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            vec_addr_q  <= 32'd0;
            cause_q     <= 2'd0;
            misalign_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_source_q <= pc_source_d;
            pc_write_q  <= pc_write_d;
            epc_write_q <= epc_write_d;
            mem_read_q  <= mem_read_d;
            vec_addr_q  <= vec_addr_d;
            cause_q     <= cause_d;
            misalign_q  <= misalign_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pc_source = pc_source_q;
    assign pc_write  = pc_write_q;
    assign epc_write = epc_write_q;
    assign mem_read  = mem_read_q;
    assign vec_addr  = vec_addr_q;
    assign exc_cause = cause_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pc_update_sequencer.sv
// Self-checking bench for pc_update_sequencer: each transaction is expanded
// into a per-cycle list of expected outputs by a transaction-level model.
module tb_pc_update_sequencer;

    localparam int          MW = 2;
    localparam logic [31:0] VB = 32'd253;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0, instr_valid = 1'b0, branch_taken = 1'b0;
    logic        exc_opcode = 1'b0, exc_overflow = 1'b0, exc_div0 = 1'b0;
    logic [2:0]  pc_op = 3'd0;
    logic [1:0]  target_lo = 2'd0;
    logic [2:0]  pc_source;
    logic        pc_write, epc_write, mem_read, busy, done;
    logic [31:0] vec_addr;
    logic [1:0]  exc_cause;

    int tests_run = 0;
    int tests_failed = 0;

    // {busy, done, pc_write, epc_write, mem_read, pc_source, exc_cause, vec_addr}
    logic [41:0] exp_q[$];
    logic [2:0]  m_src = 3'd0;
    logic [1:0]  m_cause = 2'd0;

    pc_update_sequencer #(.MEM_WAIT(MW), .VEC_BASE(VB)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .instr_valid  (instr_valid),
        .pc_op        (pc_op),
        .branch_taken (branch_taken),
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_div0     (exc_div0),
        .target_lo    (target_lo),
        .pc_source    (pc_source),
        .pc_write     (pc_write),
        .epc_write    (epc_write),
        .mem_read     (mem_read),
        .vec_addr     (vec_addr),
        .exc_cause    (exc_cause),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [41:0] observed();
        return {busy, done, pc_write, epc_write, mem_read, pc_source, exc_cause, vec_addr};
    endfunction

    task automatic push_e(input bit b, input bit d, input bit pw, input bit ew, input bit mr,
                          input logic [2:0] s, input logic [1:0] c, input logic [31:0] va);
        exp_q.push_back({b, d, pw, ew, mr, s, c, va});
    endtask

    // Exception entry: EPC save, MW cycles of vector read, PC load, then done in IDLE.
    task automatic model_exc(input logic [1:0] c);
        m_cause = c;
        push_e(1, 0, 0, 1, 0, m_src, m_cause, 32'd0);
        for (int i = 0; i < MW; i++) push_e(1, 0, 0, 0, 1, m_src, m_cause, VB + 32'(c));
        m_src = 3'd0;
        push_e(1, 0, 1, 0, 0, m_src, m_cause, 32'd0);
        push_e(0, 1, 0, 0, 0, m_src, m_cause, 32'd0);
    endtask

    task automatic run_txn(input string name, input logic [2:0] op, input bit taken,
                           input bit opc, input bit ovf, input bit dv0,
                           input logic [1:0] tlo, input int d);
        logic [41:0] ent[$];
        logic [41:0] obs, exp_v;
        bit          wr, mis;
        logic [2:0]  s;
        int          n, ivc;
        exp_q.delete();
        m_src = 3'd1;
        push_e(1, 0, 1, 0, 0, m_src, m_cause, 32'd0);
        for (int i = 0; i <= d; i++) push_e(1, 0, 0, 0, 0, m_src, m_cause, 32'd0);
        if (opc || op > 3'd4) model_exc(2'd0);
        else if (ovf) model_exc(2'd1);
        else if (dv0) model_exc(2'd2);
        else begin
            wr = 1'b1;
            s = 3'd0;
            case (op)
                3'd0: wr = 1'b0;
                3'd1: begin wr = taken; s = 3'd2; end
                3'd2: s = 3'd3;
                3'd3: s = 3'd1;
                default: s = 3'd4;
            endcase
            mis = ALIGN && wr && (op != 3'd4) && (tlo != 2'd0);
            if (mis) begin
                push_e(1, 0, 0, 0, 0, m_src, m_cause, 32'd0);
                model_exc(2'd3);
            end else begin
                if (wr) m_src = s;
                push_e(1, 1, wr, 0, 0, m_src, m_cause, 32'd0);
            end
        end
        push_e(0, 0, 0, 0, 0, m_src, m_cause, 32'd0);
        ent = exp_q;
        n = ent.size();
        ivc = 2 + d;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c == 0) fetch_req = 1'b1;
            else fetch_req = (ent[c-1][41] || ent[c-1][40]) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c == ivc) begin
                instr_valid = 1'b1; pc_op = op; branch_taken = taken;
                exc_opcode = opc; exc_overflow = ovf; exc_div0 = dv0; target_lo = tlo;
            end else begin
                instr_valid = (c >= 2 && c < ivc) ? 1'b0 : 1'($urandom_range(0, 1));
                pc_op = 3'($urandom_range(0, 7)); branch_taken = 1'($urandom_range(0, 1));
                exc_opcode = 1'($urandom_range(0, 1)); exc_overflow = 1'($urandom_range(0, 1));
                exc_div0 = 1'($urandom_range(0, 1)); target_lo = 2'($urandom_range(0, 3));
            end
            @(posedge clk);
            #1;
            obs = observed();
            exp_v = exp_q.pop_front();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: got %h expected %h (busy,done,pw,ew,mr,src,cause,vaddr)",
                         name, c + 1, obs, exp_v);
            end
        end
        @(negedge clk);
        fetch_req = 1'b0;
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (observed() !== 42'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected 0", observed());
        end
        @(negedge clk);
        reset = 1'b0;
        m_src = 3'd0;
        m_cause = 2'd0;
        @(posedge clk);
        #1;
        tests_run++;
        if (observed() !== 42'd0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got %h expected 0", observed());
        end
    endtask

    task automatic test_seq();
        run_txn("seq", 3'd0, 0, 0, 0, 0, 2'd0, 0);
        run_txn("seq_delay", 3'd0, 0, 0, 0, 0, 2'd0, 2);
    endtask

    task automatic test_branch();
        run_txn("branch_taken", 3'd1, 1, 0, 0, 0, 2'd0, 0);
        run_txn("branch_not_taken", 3'd1, 0, 0, 0, 0, 2'd0, 1);
    endtask

    task automatic test_jump_rte();
        run_txn("jump", 3'd2, 0, 0, 0, 0, 2'd0, 0);
        run_txn("rte", 3'd4, 0, 0, 0, 0, 2'd0, 0);
        run_txn("jr", 3'd3, 0, 0, 0, 0, 2'd0, 1);
    endtask

    task automatic test_exception();
        run_txn("ovf_div0", 3'd0, 0, 0, 1, 1, 2'd0, 1);
        run_txn("div0_only", 3'd2, 0, 0, 0, 1, 2'd0, 0);
        run_txn("illegal_op6", 3'd6, 0, 0, 0, 0, 2'd0, 0);
    endtask

    task automatic test_reset_mid_sequence();
        @(negedge clk);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        @(negedge clk);
        instr_valid = 1'b1; pc_op = 3'd0; exc_opcode = 1'b0; exc_overflow = 1'b1; exc_div0 = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (mem_read !== 1'b1 || vec_addr !== VB + 32'd1) begin
            tests_failed++;
            $display("FAIL mid_exc_mem: got mem_read=%b vec_addr=%0d expected 1/%0d",
                     mem_read, vec_addr, VB + 32'd1);
        end
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (observed() !== 42'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %h expected 0", observed());
        end
        @(negedge clk);
        reset = 1'b0;
        m_src = 3'd0;
        m_cause = 2'd0;
        run_txn("after_reset_seq", 3'd0, 0, 0, 0, 0, 2'd0, 0);
    endtask

    task automatic test_align();
        run_txn("align_jump", 3'd2, 0, 0, 0, 0, 2'd2, 0);
        run_txn("align_jr", 3'd3, 0, 0, 0, 0, 2'd1, 0);
        run_txn("align_rte_unchecked", 3'd4, 0, 0, 0, 0, 2'd3, 0);
        run_txn("align_seq_unchecked", 3'd0, 0, 0, 0, 0, 2'd1, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            run_txn("random", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_seq();
        test_branch();
        test_jump_rte();
        test_exception();
        test_reset_mid_sequence();
        test_align();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
